// File: rtl/decode_stage_pkg.sv
// Shared types and opcode constants for the RV32I/RV64I decode stage.
// decoded_t carries 64-bit pc/imm so it is independent of the XLEN parameter.
package decode_stage_pkg;

   typedef logic [2:0] u3;
   typedef logic [4:0] u5;
   typedef logic [6:0] u7;
   typedef u5          reg_addr;

   typedef enum logic [2:0] {
      FMT_R    = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_NONE = 3'd6
   } inst_fmt_t;

   localparam u7 OPC_LUI     = 7'b0110111;
   localparam u7 OPC_AUIPC   = 7'b0010111;
   localparam u7 OPC_JAL     = 7'b1101111;
   localparam u7 OPC_JALR    = 7'b1100111;
   localparam u7 OPC_BRANCH  = 7'b1100011;
   localparam u7 OPC_LOAD    = 7'b0000011;
   localparam u7 OPC_STORE   = 7'b0100011;
   localparam u7 OPC_OPIMM   = 7'b0010011;
   localparam u7 OPC_OP      = 7'b0110011;
   localparam u7 OPC_OPIMM32 = 7'b0011011;
   localparam u7 OPC_OP32    = 7'b0111011;

   typedef struct packed {
      logic [63:0] pc;
      u7           opcode;
      u3           funct3;
      u7           funct7;
      reg_addr     rs1;
      reg_addr     rs2;
      reg_addr     rd;
      logic [63:0] imm;
      inst_fmt_t   fmt;
      logic        illegal;
   } decoded_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: picks the format's bit layout and
// sign-extends from instr[31] to XLEN. R and NONE produce zero.
module imm_gen
   import decode_stage_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0]     instr,
   input  inst_fmt_t       fmt,
   output logic [XLEN-1:0] imm
);

   logic [31:0] imm32;

   always_comb begin
      imm32 = '0;
      case (fmt)
         FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
         FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_U:   imm32 = {instr[31:12], 12'b0};
         FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm32 = '0;
      endcase
      imm = XLEN'(signed'(imm32));
   end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I/RV64I decode stage with valid/ready on both sides and a
// 2-entry (main + skid) buffer so in_ready never depends on out_ready.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int XLEN     = 64,
   parameter bit ENABLE_W = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [31:0]     in_instr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [6:0]      out_opcode,
   output logic [2:0]      out_funct3,
   output logic [6:0]      out_funct7,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_illegal
);

   localparam bit W_OK = ENABLE_W && (XLEN == 64);

   inst_fmt_t       fmt_raw;
   inst_fmt_t       fmt;
   logic            illegal;
   logic [XLEN-1:0] imm;
   decoded_t        dec;

   decoded_t main_q, main_d, skid_q, skid_d;
   logic     main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
   logic     acc;

   always_comb begin
      fmt_raw = FMT_NONE;
      case (in_instr[6:0])
         OPC_OP:                              fmt_raw = FMT_R;
         OPC_OP32:                            fmt_raw = W_OK ? FMT_R : FMT_NONE;
         OPC_OPIMM, OPC_LOAD, OPC_JALR:       fmt_raw = FMT_I;
         OPC_OPIMM32:                         fmt_raw = W_OK ? FMT_I : FMT_NONE;
         OPC_STORE:                           fmt_raw = FMT_S;
         OPC_BRANCH:                          fmt_raw = FMT_B;
         OPC_LUI, OPC_AUIPC:                  fmt_raw = FMT_U;
         OPC_JAL:                             fmt_raw = FMT_J;
         default:                             fmt_raw = FMT_NONE;
      endcase
      illegal = (fmt_raw == FMT_NONE) || (in_instr[1:0] != 2'b11);
      fmt     = illegal ? FMT_NONE : fmt_raw;
   end

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr (in_instr),
      .fmt   (fmt),
      .imm   (imm)
   );

   // Register fields are zeroed whenever the format does not use them.
   always_comb begin
      dec         = '0;
      dec.pc      = 64'(in_pc);
      dec.opcode  = in_instr[6:0];
      dec.funct3  = in_instr[14:12];
      dec.funct7  = in_instr[31:25];
      dec.rs1     = (fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) ? in_instr[19:15] : 5'd0;
      dec.rs2     = (fmt inside {FMT_R, FMT_S, FMT_B})        ? in_instr[24:20] : 5'd0;
      dec.rd      = (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) ? in_instr[11:7]  : 5'd0;
      dec.imm     = 64'(imm);
      dec.fmt     = fmt;
      dec.illegal = illegal;
   end

   assign in_ready = !skid_vld_q;

   always_comb begin
      main_d     = main_q;
      main_vld_d = main_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      acc        = in_valid && !skid_vld_q && !flush;
      if (flush) begin
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (!main_vld_q || out_ready) begin
         // Main slot frees up: the oldest held entry (skid) moves forward first.
         if (skid_vld_q) begin
            main_d     = skid_q;
            main_vld_d = 1'b1;
            skid_vld_d = acc;
            if (acc) skid_d = dec;
         end else begin
            main_vld_d = acc;
            if (acc) main_d = dec;
         end
      end else if (acc) begin
         skid_d     = dec;
         skid_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
      end
   end

   assign out_valid   = main_vld_q;
   assign out_pc      = main_q.pc[XLEN-1:0];
   assign out_opcode  = main_q.opcode;
   assign out_funct3  = main_q.funct3;
   assign out_funct7  = main_q.funct7;
   assign out_rs1     = main_q.rs1;
   assign out_rs2     = main_q.rs2;
   assign out_rd      = main_q.rd;
   assign out_imm     = main_q.imm[XLEN-1:0];
   assign out_fmt     = main_q.fmt;
   assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected decodes are queued on accept and
// compared when EX takes them; a second XLEN=32/ENABLE_W=0 instance covers RV32 cases.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0, out_ready = 1'b1;
   logic        in_ready, out_valid;
   logic [63:0] in_pc = '0;
   logic [31:0] in_instr = '0;
   logic [63:0] out_pc, out_imm;
   logic [6:0]  out_opcode, out_funct7;
   logic [2:0]  out_funct3, out_fmt;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   logic        out_illegal;

   logic        in_valid2 = 1'b0;
   logic        in_ready2, out_valid2, out_illegal2;
   logic [31:0] in_pc2 = '0, in_instr2 = '0;
   logic [31:0] out_pc2, out_imm2;
   logic [6:0]  out_opcode2, out_funct72;
   logic [2:0]  out_funct32, out_fmt2;
   logic [4:0]  out_rs12, out_rs22, out_rd2;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(64), .ENABLE_W(1'b1)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
      .out_fmt(out_fmt), .out_illegal(out_illegal)
   );

   decode_stage #(.XLEN(32), .ENABLE_W(1'b0)) dut32 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid2), .in_ready(in_ready2), .in_pc(in_pc2), .in_instr(in_instr2),
      .out_valid(out_valid2), .out_ready(1'b1), .out_pc(out_pc2),
      .out_opcode(out_opcode2), .out_funct3(out_funct32), .out_funct7(out_funct72),
      .out_rs1(out_rs12), .out_rs2(out_rs22), .out_rd(out_rd2), .out_imm(out_imm2),
      .out_fmt(out_fmt2), .out_illegal(out_illegal2)
   );

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
      logic [2:0]  fmt;
      logic [4:0]  rd, rs1, rs2;
      logic [63:0] imm;
      logic        ill;
   } exp_t;

   exp_t cur;
   exp_t sb[$];
   int   total = 0, passed = 0, failed = 0, pops = 0;
   logic        stalled = 1'b0;
   logic [63:0] hold_pc, hold_imm;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic present(input logic [63:0] pc, input logic [31:0] instr, input logic [2:0] fmt,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [63:0] imm, input logic ill);
      in_valid = 1'b1;
      in_pc    = pc;
      in_instr = instr;
      cur.pc = pc; cur.instr = instr; cur.fmt = fmt;
      cur.rd = rd; cur.rs1 = rs1; cur.rs2 = rs2; cur.imm = imm; cur.ill = ill;
   endtask

   // One clock: observe at the falling edge, then advance past the rising edge.
   task automatic step(output logic accepted);
      exp_t e;
      @(negedge clk);
      if (stalled && out_valid) begin
         chk("stall_hold_pc", out_pc, hold_pc);
         chk("stall_hold_imm", out_imm, hold_imm);
      end
      accepted = in_valid && in_ready && !flush;
      if (flush) begin
         sb.delete();
      end else if (out_valid && out_ready) begin
         if (sb.size() == 0) chk("unexpected_out", {63'd0, out_valid}, 64'd0);
         else begin
            e = sb.pop_front();
            pops++;
            chk("pc", out_pc, e.pc);
            chk("passthru", {out_funct7, out_funct3, out_opcode}, {e.instr[31:25], e.instr[14:12], e.instr[6:0]});
            chk("fields", {out_fmt, out_rd, out_rs1, out_rs2, out_illegal}, {e.fmt, e.rd, e.rs1, e.rs2, e.ill});
            chk("imm", out_imm, e.imm);
         end
      end
      if (accepted) sb.push_back(cur);
      stalled  = out_valid && !out_ready;
      hold_pc  = out_pc;
      hold_imm = out_imm;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic got;
      int   acc_n, base;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_pc", out_pc, 64'd0);
      chk("rst_out_imm", out_imm, 64'd0);
      chk("rst_fields", {out_fmt, out_rd, out_rs1, out_rs2, out_illegal}, 64'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

      // Directed decodes, one per cycle with EX always ready.
      out_ready = 1'b1;
      present(64'h100, 32'hFFF10093, 3'd1, 5'd1, 5'd2, 5'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0); step(got);
      chk("latency_1", {63'd0, out_valid}, 64'd1);
      present(64'h104, 32'h00512423, 3'd2, 5'd0, 5'd2, 5'd5, 64'd8, 1'b0);               step(got);
      present(64'h108, 32'hFE000EE3, 3'd3, 5'd0, 5'd0, 5'd0, 64'hFFFFFFFFFFFFFFFC, 1'b0); step(got);
      present(64'h10C, 32'h123450B7, 3'd4, 5'd1, 5'd0, 5'd0, 64'h12345000, 1'b0);         step(got);
      present(64'h110, 32'h008000EF, 3'd5, 5'd1, 5'd0, 5'd0, 64'd8, 1'b0);                step(got);
      present(64'h114, 32'h002081B3, 3'd0, 5'd3, 5'd1, 5'd2, 64'd0, 1'b0);                step(got);
      present(64'h118, 32'h00000000, 3'd6, 5'd0, 5'd0, 5'd0, 64'd0, 1'b1);                step(got);
      present(64'h11C, 32'h0010809B, 3'd1, 5'd1, 5'd1, 5'd0, 64'd1, 1'b0);                step(got);
      in_valid = 1'b0;
      step(got);
      step(got);
      chk("directed_drained", 64'(sb.size()), 64'd0);
      chk("directed_pops", 64'(pops), 64'd8);

      // Backpressure: 5-instruction stream, EX stalls for cycles 2..4.
      acc_n = 0;
      base  = pops;
      for (int c = 0; c < 40 && pops < base + 5; c++) begin
         out_ready = !(c >= 2 && c <= 4);
         if (acc_n < 5)
            present(64'h2000 + 64'(4 * (acc_n + 1)), ((acc_n + 1) << 20) | ((acc_n + 1) << 7) | 32'h13,
                    3'd1, 5'(acc_n + 1), 5'd0, 5'd0, 64'(acc_n + 1), 1'b0);
         else
            in_valid = 1'b0;
         if (c == 3) chk("in_ready_stall", {63'd0, in_ready}, 64'd0);
         step(got);
         if (got) acc_n++;
      end
      in_valid = 1'b0;
      chk("stream_pops", 64'(pops - base), 64'd5);
      chk("stream_drained", 64'(sb.size()), 64'd0);

      // Flush with both entries full and a new instruction offered.
      out_ready = 1'b0;
      present(64'h3000, 32'h00100093, 3'd1, 5'd1, 5'd0, 5'd0, 64'd1, 1'b0); step(got);
      present(64'h3004, 32'h00200113, 3'd1, 5'd2, 5'd0, 5'd0, 64'd2, 1'b0); step(got);
      chk("full_in_ready", {63'd0, in_ready}, 64'd0);
      present(64'h3008, 32'h00300193, 3'd1, 5'd3, 5'd0, 5'd0, 64'd3, 1'b0);
      flush = 1'b1;
      step(got);
      flush = 1'b0;
      chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
      chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
      // Flush also beats an accept that would otherwise succeed.
      present(64'h300C, 32'h00400213, 3'd1, 5'd4, 5'd0, 5'd0, 64'd4, 1'b0);
      flush = 1'b1;
      step(got);
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("flush_drop_valid", {63'd0, out_valid}, 64'd0);
      repeat (3) step(got);
      chk("flush_nothing_left", 64'(sb.size()), 64'd0);

      // Async reset while EX is stalling.
      out_ready = 1'b0;
      present(64'h4000, 32'h00500293, 3'd1, 5'd5, 5'd0, 5'd0, 64'd5, 1'b0); step(got);
      in_valid = 1'b0;
      step(got);
      chk("prereset_valid", {63'd0, out_valid}, 64'd1);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
      chk("async_rst_pc", out_pc, 64'd0);
      sb.delete();
      stalled = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      out_ready = 1'b1;
      repeat (3) step(got);
      chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

      // RV32 instance: lui sign/width and OP-IMM-32 rejected.
      in_instr2 = 32'h123450B7; in_pc2 = 32'h80; in_valid2 = 1'b1;
      @(posedge clk); #1 in_valid2 = 1'b0;
      chk("rv32_lui_valid", {63'd0, out_valid2}, 64'd1);
      chk("rv32_lui_imm", {32'd0, out_imm2}, 64'h12345000);
      chk("rv32_lui_fields", {out_fmt2, out_rd2, out_rs12, out_rs22, out_illegal2}, {3'd4, 5'd1, 5'd0, 5'd0, 1'b0});
      chk("rv32_lui_pc", {32'd0, out_pc2}, 64'h80);
      in_instr2 = 32'h0010809B; in_pc2 = 32'h84; in_valid2 = 1'b1;
      @(posedge clk); #1 in_valid2 = 1'b0;
      chk("rv32_addiw_ill", {out_fmt2, out_rd2, out_rs12, out_rs22, out_illegal2}, {3'd6, 5'd0, 5'd0, 5'd0, 1'b1});
      chk("rv32_addiw_imm", {32'd0, out_imm2}, 64'd0);
      chk("rv32_addiw_pass", {out_funct72, out_funct32, out_opcode2}, {7'd0, 3'd0, 7'b0011011});
      chk("rv32_in_ready", {63'd0, in_ready2}, 64'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
